// File: rtl/sprite_anim_pkg.sv
// Shared types and constants for the animated sprite renderer.
package sprite_anim_pkg;

    typedef enum logic {
        ANIM_LOOP     = 1'b0,
        ANIM_PINGPONG = 1'b1
    } anim_mode_t;

    typedef enum logic {
        HOLD = 1'b0,
        PLAY = 1'b1
    } anim_state_t;

    localparam int SPR_PIPE_LAT = 3;

endpackage

// File: rtl/sprite_anim_render_seq.sv
// Animation sequencer: frame-start detection, hold counter, direction and frame index.
// With SPRITE_MIRROR_EN defined, it also latches the mirror flag at each frame start.
module sprite_anim_seq
    import sprite_anim_pkg::*;
#(
    parameter int NUM_FRAMES = 8,
    parameter int FRAME_HOLD = 6,
    parameter int FI_W       = 3
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            at_origin_i,
    input  logic            play_i,
    input  logic            anim_mode_i,
`ifdef SPRITE_MIRROR_EN
    input  logic            mirror_i,
    output logic            mirror_o,
`endif
    output logic [FI_W-1:0] frame_idx_o
);

    localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(FRAME_HOLD - 1);
    localparam logic [FI_W-1:0]   LAST_FRAME = FI_W'(NUM_FRAMES - 1);

    anim_state_t       state_q, state_d;
    anim_mode_t        mode;
    logic              origin_q;
    logic              sof;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              dir_down_q, dir_down_d;
    logic [FI_W-1:0]   frame_q, frame_d;

    assign mode = anim_mode_t'(anim_mode_i);
    // Edge-detect so a dwelling pixel counter yields only one pulse per frame
    assign sof  = at_origin_i && !origin_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dir_down_d = dir_down_q;
        frame_d    = frame_q;
        case (state_q)
            HOLD:    if (play_i)  state_d = PLAY;
            PLAY:    if (!play_i) state_d = HOLD;
            default: state_d = HOLD;
        endcase
        // Live play input decides, so a toggle coinciding with the pulse is honoured
        if (play_i && sof) begin
            if (cnt_q == HOLD_LAST) begin
                cnt_d = '0;
                if (NUM_FRAMES > 1) begin
                    if (mode == ANIM_LOOP) begin
                        dir_down_d = 1'b0;
                        frame_d    = (frame_q == LAST_FRAME) ? '0 : frame_q + 1'b1;
                    end else if (!dir_down_q) begin
                        if (frame_q == LAST_FRAME) begin
                            dir_down_d = 1'b1;
                            frame_d    = frame_q - 1'b1;
                        end else begin
                            frame_d    = frame_q + 1'b1;
                        end
                    end else begin
                        if (frame_q == '0) begin
                            dir_down_d = 1'b0;
                            frame_d    = frame_q + 1'b1;
                        end else begin
                            frame_d    = frame_q - 1'b1;
                        end
                    end
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= HOLD;
            origin_q   <= 1'b0;
            cnt_q      <= '0;
            dir_down_q <= 1'b0;
            frame_q    <= '0;
        end else begin
            state_q    <= state_d;
            origin_q   <= at_origin_i;
            cnt_q      <= cnt_d;
            dir_down_q <= dir_down_d;
            frame_q    <= frame_d;
        end
    end

`ifdef SPRITE_MIRROR_EN
    logic mirror_q;
    always_ff @(posedge clk_i) begin
        if (!rst_n_i)  mirror_q <= 1'b0;
        else if (sof)  mirror_q <= mirror_i;
    end
    assign mirror_o = mirror_q;
`endif

    assign frame_idx_o = frame_q;

endmodule

// File: rtl/sprite_anim_render.sv
// Multi-frame scaled sprite renderer: 3-cycle geometry -> ROM -> palette pipeline.
// Optional horizontal mirroring is enabled by defining SPRITE_MIRROR_EN.
module sprite_anim_render
    import sprite_anim_pkg::*;
#(
    parameter int SPR_W      = 110,
    parameter int SPR_H      = 96,
    parameter int NUM_FRAMES = 8,
    parameter int SCALE_LOG2 = 1,
    parameter int FRAME_HOLD = 6,
    parameter int TRANSP_IDX = 0,
    parameter int ADDR_W     = $clog2(SPR_W * SPR_H * NUM_FRAMES),
    localparam int FI_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic              play,
    input  logic              anim_mode,
`ifdef SPRITE_MIRROR_EN
    input  logic              mirror,
`endif
    output logic [ADDR_W-1:0] rom_address,
    input  logic [3:0]        rom_q,
    output logic [3:0]        pal_index,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              hit,
    output logic [FI_W-1:0]   frame_idx
);

    localparam int              FRAME_SZ = SPR_W * SPR_H;
    localparam logic [10:0]     BOX_W    = 11'(SPR_W << SCALE_LOG2);
    localparam logic [10:0]     BOX_H    = 11'(SPR_H << SCALE_LOG2);
    localparam logic [10:0]     U_LAST   = 11'(SPR_W - 1);
    localparam logic [3:0]      TRANSP   = 4'(TRANSP_IDX);

    logic              mirror_en;
    logic [10:0]       dx_p0, dy_p0, u_p0, v_p0, u_eff_p0;
    logic              in_box_p0;
    logic [ADDR_W-1:0] rom_address_q, rom_address_d;
    logic              in_box_p1_q, blank_p1_q;
    logic              in_box_p2_q, blank_p2_q;
    logic              hit_q, hit_d;
    logic [3:0]        red_q, green_q, blue_q;

    sprite_anim_seq #(
        .NUM_FRAMES (NUM_FRAMES),
        .FRAME_HOLD (FRAME_HOLD),
        .FI_W       (FI_W)
    ) u_seq (
        .clk_i       (vga_clk),
        .rst_n_i     (reset_n),
        .at_origin_i (DrawX == 10'd0 && DrawY == 10'd0),
        .play_i      (play),
        .anim_mode_i (anim_mode),
`ifdef SPRITE_MIRROR_EN
        .mirror_i    (mirror),
        .mirror_o    (mirror_en),
`endif
        .frame_idx_o (frame_idx)
    );

`ifndef SPRITE_MIRROR_EN
    assign mirror_en = 1'b0;
`endif

    // Stage 0: unsigned underflow pushes left/above positions outside the box
    assign dx_p0     = {1'b0, DrawX} - {1'b0, sprite_x};
    assign dy_p0     = {1'b0, DrawY} - {1'b0, sprite_y};
    assign in_box_p0 = (dx_p0 < BOX_W) && (dy_p0 < BOX_H);
    assign u_p0      = dx_p0 >> SCALE_LOG2;
    assign v_p0      = dy_p0 >> SCALE_LOG2;
    assign u_eff_p0  = mirror_en ? (U_LAST - u_p0) : u_p0;

    assign rom_address_d = in_box_p0
        ? (ADDR_W'(frame_idx) * ADDR_W'(FRAME_SZ) + ADDR_W'(v_p0) * ADDR_W'(SPR_W) + ADDR_W'(u_eff_p0))
        : rom_address_q;

    // Stage 2: rom_q arrives one cycle after the address
    assign pal_index = rom_q;
    assign hit_d     = blank_p2_q && in_box_p2_q && (rom_q != TRANSP);

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            rom_address_q <= '0;
            in_box_p1_q   <= 1'b0;
            blank_p1_q    <= 1'b0;
            in_box_p2_q   <= 1'b0;
            blank_p2_q    <= 1'b0;
            hit_q         <= 1'b0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
        end else begin
            rom_address_q <= rom_address_d;
            in_box_p1_q   <= in_box_p0;
            blank_p1_q    <= blank;
            in_box_p2_q   <= in_box_p1_q;
            blank_p2_q    <= blank_p1_q;
            // Stage 3: registered colour, black unless opaque
            hit_q         <= hit_d;
            red_q         <= hit_d ? pal_red   : 4'd0;
            green_q       <= hit_d ? pal_green : 4'd0;
            blue_q        <= hit_d ? pal_blue  : 4'd0;
        end
    end

    assign rom_address = rom_address_q;
    assign hit         = hit_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;

endmodule

// File: tb/tb_sprite_anim_render.sv
// Testbench for sprite_anim_render: vector table + scoreboard, then animation sequences.
module tb_sprite_anim_render;
    import sprite_anim_pkg::*;

    localparam int ADDR_W = 17;
    localparam int NV     = 12;

    logic              vga_clk = 1'b0;
    logic              reset_n;
    logic [9:0]        DrawX, DrawY, sprite_x, sprite_y;
    logic              blank, play, anim_mode;
    logic [ADDR_W-1:0] rom_address;
    logic [3:0]        rom_q = 4'd0;
    logic [3:0]        pal_index, pal_red, pal_green, pal_blue;
    logic [3:0]        red, green, blue;
    logic              hit;
    logic [2:0]        frame_idx;
`ifdef SPRITE_MIRROR_EN
    logic              mirror;
`endif

    always #5 vga_clk = ~vga_clk;

    sprite_anim_render dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .play        (play),
        .anim_mode   (anim_mode),
`ifdef SPRITE_MIRROR_EN
        .mirror      (mirror),
`endif
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .pal_index   (pal_index),
        .pal_red     (pal_red),
        .pal_green   (pal_green),
        .pal_blue    (pal_blue),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .hit         (hit),
        .frame_idx   (frame_idx)
    );

    function automatic logic [3:0] rom_fn(input logic [ADDR_W-1:0] a);
        logic [3:0] lo;
        lo = a[3:0];
        return lo + 4'd5;
    endfunction

    function automatic logic [11:0] pal_rgb(input logic [3:0] idx);
        return {idx, ~idx, idx ^ 4'hA};
    endfunction

    // Synchronous ROM and combinational palette models
    always @(posedge vga_clk) rom_q <= rom_fn(rom_address);
    assign pal_red   = pal_index;
    assign pal_green = ~pal_index;
    assign pal_blue  = pal_index ^ 4'hA;

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [9:0]        x;
        logic [9:0]        y;
        logic              blank;
        logic              exp_hit;
        logic [ADDR_W-1:0] exp_addr;
    } vec_t;

    typedef struct {
        int          due;
        int          id;
        logic        hit;
        logic [11:0] rgb;
    } exp_t;

    typedef struct {
        int                due;
        int                id;
        logic [ADDR_W-1:0] addr;
    } aexp_t;

    vec_t  vt[NV];
    exp_t  sb[$];
    aexp_t asb[$];

    function automatic vec_t mk(input int x, input int y, input int b, input int h, input int a);
        vec_t v;
        v.x = 10'(x); v.y = 10'(y); v.blank = 1'(b); v.exp_hit = 1'(h); v.exp_addr = ADDR_W'(a);
        return v;
    endfunction

    task automatic pulse();
        @(negedge vga_clk); DrawX = 10'd0; DrawY = 10'd0;
        @(negedge vga_clk); DrawX = 10'd1; DrawY = 10'd0;
    endtask

    initial begin
        exp_t  e;
        aexp_t a;
        int    pp[15];

        // sprite at (100,50), scale 2: box is 220 x 192 screen pixels
        vt[0]  = mk(100,  50, 1, 1, 0);
        vt[1]  = mk(319,  50, 1, 1, 109);
        vt[2]  = mk(320,  50, 1, 0, 109);
        vt[3]  = mk( 99,  50, 1, 0, 109);
        vt[4]  = mk(122,  50, 1, 0, 11);
        vt[5]  = mk(100,  50, 0, 0, 0);
        vt[6]  = mk(101,  51, 1, 1, 0);
        vt[7]  = mk(102,  52, 1, 1, 111);
        vt[8]  = mk(100, 241, 1, 1, 10450);
        vt[9]  = mk(100, 242, 1, 0, 10450);
        vt[10] = mk(319, 241, 1, 1, 10559);
        vt[11] = mk(100,  49, 1, 0, 10559);
        pp = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

        reset_n = 1'b0; DrawX = 10'd500; DrawY = 10'd400; blank = 1'b0;
        sprite_x = 10'd100; sprite_y = 10'd50; play = 1'b0; anim_mode = 1'b0;
`ifdef SPRITE_MIRROR_EN
        mirror = 1'b0;
`endif
        repeat (3) @(negedge vga_clk);
        check("rst_addr",  32'(rom_address), 32'd0);
        check("rst_hit",   32'(hit), 32'd0);
        check("rst_rgb",   32'({red, green, blue}), 32'd0);
        check("rst_frame", 32'(frame_idx), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < NV + SPR_PIPE_LAT + 1; i++) begin
            @(negedge vga_clk);
            while (asb.size() > 0 && asb[0].due <= cyc) begin
                a = asb.pop_front();
                check($sformatf("addr[%0d]", a.id), 32'(rom_address), 32'(a.addr));
            end
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check($sformatf("hit[%0d]", e.id), 32'(hit), 32'(e.hit));
                check($sformatf("rgb[%0d]", e.id), 32'({red, green, blue}), 32'(e.rgb));
            end
            if (i < NV) begin
                DrawX = vt[i].x; DrawY = vt[i].y; blank = vt[i].blank;
                a.due = cyc + 1; a.id = i; a.addr = vt[i].exp_addr;
                asb.push_back(a);
                e.due = cyc + SPR_PIPE_LAT; e.id = i; e.hit = vt[i].exp_hit;
                e.rgb = vt[i].exp_hit ? pal_rgb(rom_fn(vt[i].exp_addr)) : 12'd0;
                sb.push_back(e);
            end
        end
        check("sb_drained", 32'(sb.size() + asb.size()), 32'd0);

        // LOOP: one frame step every 6 frame-start pulses
        blank = 1'b0; play = 1'b1; anim_mode = 1'b0;
        for (int p = 1; p <= 48; p++) begin
            pulse();
            check($sformatf("loop_p%0d", p), 32'(frame_idx), 32'((p / 6) % 8));
            if (p == 6) begin
                DrawX = 10'd100; DrawY = 10'd50;
                @(negedge vga_clk);
                check("frame1_offset", 32'(rom_address), 32'd10560);
            end
        end

        anim_mode = 1'b1;
        for (int s = 0; s < 15; s++) begin
            repeat (6) pulse();
            check($sformatf("pp_s%0d", s), 32'(frame_idx), 32'(pp[s]));
        end

        play = 1'b0;
        repeat (12) pulse();
        check("hold_frozen", 32'(frame_idx), 32'd1);

        // Counters dwelling at the origin must count as a single pulse
        play = 1'b1;
        @(negedge vga_clk); DrawX = 10'd0; DrawY = 10'd0;
        repeat (8) @(negedge vga_clk);
        DrawX = 10'd1;
        @(negedge vga_clk);
        check("dwell_once", 32'(frame_idx), 32'd1);
        repeat (5) pulse();
        check("dwell_then_step", 32'(frame_idx), 32'd2);
        repeat (18) pulse();
        check("reach_5", 32'(frame_idx), 32'd5);

        // Reset mid-line while a frame-5 pixel is being drawn
        play = 1'b0; DrawX = 10'd100; DrawY = 10'd50; blank = 1'b1;
        repeat (3) @(negedge vga_clk);
        check("pre_rst_hit", 32'(hit), 32'd1);
        reset_n = 1'b0;
        @(negedge vga_clk);
        check("mid_rst_frame", 32'(frame_idx), 32'd0);
        check("mid_rst_hit",   32'(hit), 32'd0);
        check("mid_rst_rgb",   32'({red, green, blue}), 32'd0);
        check("mid_rst_addr",  32'(rom_address), 32'd0);
        reset_n = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            @(negedge vga_clk);
            check($sformatf("post_rst_black%0d", k), 32'({hit, red, green, blue}), 32'd0);
        end
        @(negedge vga_clk);
        check("post_rst_hit", 32'(hit), 32'd1);
        check("post_rst_rgb", 32'({red, green, blue}), 32'(pal_rgb(4'd5)));

`ifdef SPRITE_MIRROR_EN
        mirror = 1'b1; blank = 1'b0;
        pulse();
        DrawX = 10'd100; DrawY = 10'd50;
        @(negedge vga_clk);
        check("mirror_addr", 32'(rom_address), 32'd109);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
